// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: synchronizes rx_i, deframes bytes with a divisor-driven sampler,
// and buffers them in a first-word-fall-through FIFO with sticky error flags.
module uart_rx_fifo #(
  parameter int unsigned FifoDepth  = 8,
  parameter int unsigned DivW       = 16,
  parameter int unsigned SyncStages = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           rx_i,
  input  logic                           rx_en_i,
  input  logic [DivW-1:0]                baud_div_i,
  output logic [7:0]                     data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [$clog2(FifoDepth):0]     count_o,
  output logic                           frame_err_o,
  output logic                           overflow_o,
  input  logic                           clear_err_i,
  output logic                           busy_o
);

  localparam int unsigned AW = $clog2(FifoDepth);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  logic [SyncStages-1:0] sync_q;
  logic                  rxs_prev_q;
  logic                  rxs;
  logic                  fall_c;

  state_e                state_q;
  logic [DivW-1:0]       cyc_q;
  logic [2:0]            bit_q;
  logic [7:0]            shift_q;
  logic                  busy_q;

  logic [7:0]            mem_q [FifoDepth];
  logic [AW-1:0]         wptr_q;
  logic [AW-1:0]         rptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  valid_q;
  logic                  frame_err_q;
  logic                  overflow_q;

  logic                  sample_c;
  logic                  stop_ok_c;
  logic                  stop_bad_c;
  logic                  full_c;
  logic                  pop_c;
  logic                  push_c;
  logic                  ovf_c;

  // Metastability synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SyncStages-2:0], rx_i};
      rxs_prev_q <= rxs;
    end
  end

  assign rxs    = sync_q[SyncStages-1];
  assign fall_c = rxs_prev_q & ~rxs;

  assign sample_c   = (state_q != ST_IDLE) && rx_en_i && (cyc_q == '0);
  assign stop_ok_c  = sample_c && (state_q == ST_STOP) && rxs;
  assign stop_bad_c = sample_c && (state_q == ST_STOP) && !rxs;

  assign full_c = (count_q == CW'(FifoDepth));
  assign pop_c  = valid_q && ready_i;
  assign push_c = stop_ok_c && (!full_c || pop_c);
  assign ovf_c  = stop_ok_c && full_c && !pop_c;

  // Frame FSM; a held-low line after a bad stop bit cannot restart it until rxs rises again
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (rx_en_i && fall_c) begin
        state_q <= ST_START;
        cyc_q   <= baud_div_i >> 1;
        busy_q  <= 1'b1;
      end
    end else if (!rx_en_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else if (cyc_q != '0) begin
      cyc_q <= cyc_q - DivW'(1);
    end else begin
      cyc_q <= baud_div_i - DivW'(1);
      case (state_q)
        ST_START: begin
          if (!rxs) begin
            state_q <= ST_DATA;
            bit_q   <= 3'd0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_DATA: begin
          shift_q <= {rxs, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_q <= ST_STOP;
          end else begin
            bit_q <= bit_q + 3'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c) begin
      count_d = count_q + CW'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - CW'(1);
    end
  end

  // Receive FIFO storage and pointers; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FifoDepth); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push_c) begin
        mem_q[wptr_q] <= shift_q;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop_c) begin
        rptr_q <= rptr_q + AW'(1);
      end
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  // Sticky error flags; a new event in the clear cycle wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= (frame_err_q & ~clear_err_i) | stop_bad_c;
      overflow_q  <= (overflow_q & ~clear_err_i) | ovf_c;
    end
  end

  assign data_o      = mem_q[rptr_q];
  assign valid_o     = valid_q;
  assign count_o     = count_q;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven onto rx_i, results compared to a queue model.
module tb_uart_rx_fifo;

  localparam int unsigned Depth = 8;
  localparam int unsigned DivW  = 16;
  localparam int unsigned CW    = $clog2(Depth) + 1;

  logic            clk_i;
  logic            rst_ni;
  logic            rx_i;
  logic            rx_en_i;
  logic [DivW-1:0] baud_div_i;
  logic [7:0]      data_o;
  logic            valid_o;
  logic            ready_i;
  logic [CW-1:0]   count_o;
  logic            frame_err_o;
  logic            overflow_o;
  logic            clear_err_i;
  logic            busy_o;

  uart_rx_fifo #(
    .FifoDepth (Depth),
    .DivW      (DivW),
    .SyncStages(2)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rx_i       (rx_i),
    .rx_en_i    (rx_en_i),
    .baud_div_i (baud_div_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .count_o    (count_o),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .clear_err_i(clear_err_i),
    .busy_o     (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int vectors;
  int miscompares;
  logic [7:0] exp_q[$];
  logic exp_ferr;
  logic exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " count"}, 32'(count_o), 32'(exp_q.size()));
    check({tag, " valid"}, 32'(valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, " data"}, 32'(data_o), 32'(exp_q[0]));
    check({tag, " frame_err"}, 32'(frame_err_o), 32'(exp_ferr));
    check({tag, " overflow"}, 32'(overflow_o), 32'(exp_ovf));
  endtask

  task automatic check_reset(input string tag);
    check({tag, " data"}, 32'(data_o), 32'h0);
    check({tag, " valid"}, 32'(valid_o), 32'h0);
    check({tag, " count"}, 32'(count_o), 32'h0);
    check({tag, " frame_err"}, 32'(frame_err_o), 32'h0);
    check({tag, " overflow"}, 32'(overflow_o), 32'h0);
    check({tag, " busy"}, 32'(busy_o), 32'h0);
  endtask

  // One 8N1 frame, LSB first; called and returns on a falling clock edge
  task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
    rx_i = 1'b0;
    repeat (div) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (div) @(negedge clk_i);
    end
    rx_i = stop;
    repeat (div) @(negedge clk_i);
    rx_i = 1'b1;
  endtask

  // Drive a frame and apply its effect to the model
  task automatic rx_byte(input logic [7:0] b, input logic stop);
    send_frame(b, stop, int'(baud_div_i));
    if (!stop) exp_ferr = 1'b1;
    else if (exp_q.size() >= Depth) exp_ovf = 1'b1;
    else exp_q.push_back(b);
  endtask

  task automatic pop_one(input string tag);
    check({tag, " pop valid"}, 32'(valid_o), 32'h1);
    if (exp_q.size() != 0) begin
      check({tag, " pop data"}, 32'(data_o), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  task automatic clear_flags();
    clear_err_i = 1'b1;
    @(negedge clk_i);
    clear_err_i = 1'b0;
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  initial begin
    logic [7:0] msg [6];
    logic [7:0] b;
    vectors     = 0;
    miscompares = 0;
    exp_ferr    = 1'b0;
    exp_ovf     = 1'b0;
    rst_ni      = 1'b0;
    rx_i        = 1'b1;
    rx_en_i     = 1'b1;
    baud_div_i  = 16'd20;
    ready_i     = 1'b0;
    clear_err_i = 1'b0;
    msg = '{8'h53, 8'h4F, 8'h43, 8'h48, 8'h55, 8'h42};

    repeat (3) @(negedge clk_i);
    check_reset("reset");
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);

    // Single byte
    rx_byte(8'h41, 1'b1);
    check_state("byte41");
    pop_one("byte41");
    check_state("byte41 after pop");

    // Back-to-back string
    for (int i = 0; i < 6; i++) rx_byte(msg[i], 1'b1);
    check_state("sochub");
    for (int i = 0; i < 6; i++) pop_one("sochub");
    check_state("sochub drained");

    // Short glitch is rejected at the start sample
    rx_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (30) @(negedge clk_i);
    check("glitch busy", 32'(busy_o), 32'h0);
    check_state("glitch");

    // Low stop bit
    rx_byte(8'h55, 1'b0);
    repeat (2) @(negedge clk_i);
    check_state("frame err");
    clear_flags();
    check_state("frame err cleared");

    // Receiver disabled mid-frame
    fork
      send_frame(8'h3C, 1'b1, 20);
      begin
        repeat (60) @(negedge clk_i);
        check("rx_en busy mid", 32'(busy_o), 32'h1);
        rx_en_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rx_en busy off", 32'(busy_o), 32'h0);
      end
    join
    rx_en_i = 1'b1;
    repeat (5) @(negedge clk_i);
    check_state("rx_en drop");

    // Overflow with nine bytes into eight entries
    for (int i = 0; i < 9; i++) rx_byte(8'(i), 1'b1);
    check_state("overflow");
    for (int i = 0; i < 8; i++) pop_one("overflow");
    clear_flags();
    check_state("overflow drained");

    // Full FIFO with a pop landing in the stop-sample cycle
    for (int i = 0; i < 8; i++) rx_byte(8'(i), 1'b1);
    check_state("full");
    fork
      send_frame(8'h08, 1'b1, 20);
      begin
        repeat (193) @(posedge clk_i);
        @(negedge clk_i);
        check("coincident pop data", 32'(data_o), 32'(exp_q[0]));
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    exp_q.push_back(8'h08);
    check_state("coincident");
    for (int i = 0; i < 8; i++) pop_one("coincident");
    check_state("coincident drained");

    // Reset in the middle of data bit 3 with a byte already buffered
    rx_byte(8'h77, 1'b1);
    fork
      send_frame(8'hC3, 1'b1, 20);
      begin
        repeat (90) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check_reset("mid-frame reset");
      end
    join
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check_reset("after release");
    rx_byte(8'hA5, 1'b1);
    check_state("after reset A5");
    pop_one("after reset A5");

    // Randomized bytes, divisors and pops
    for (int n = 0; n < 12; n++) begin
      baud_div_i = 16'($urandom_range(8, 24));
      b = 8'($urandom);
      rx_byte(b, 1'b1);
      repeat (2) @(negedge clk_i);
      check_state("random");
      if ($urandom_range(0, 1) == 1 && exp_q.size() != 0) pop_one("random");
    end
    while (exp_q.size() != 0) pop_one("random drain");
    check_state("random drained");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
